// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues word fetches under a
// credit limit, queues returned words in order with their PC, and flushes
// on redirect while discarding responses that belong to the old path.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h038,
  parameter int          DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [63:0] MemAddr,
  output logic        MemReq,
  input  logic        MemGnt,
  input  logic        MemRspValid,
  input  logic [31:0] MemRspData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [63:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [63:0]   rq_pc_q [DEPTH];
  logic [63:0]   rq_pc_d [DEPTH];
  logic [PW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d;
  logic [31:0]   iq_data_q [DEPTH];
  logic [31:0]   iq_data_d [DEPTH];
  logic [63:0]   iq_pc_q [DEPTH];
  logic [63:0]   iq_pc_d [DEPTH];
  logic [PW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;
  logic [CW-1:0] iq_cnt_q, iq_cnt_d;

  logic          pop_head;
  logic          accept;
  logic          rsp_keep;
  logic [SW-1:0] credit_used;
  logic          rpc_unused;

  assign rpc_unused = ^RedirectPC[1:0];
  assign MemAddr    = pc_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue head presented to decode; fields read as zero while empty.
  always_comb begin
    InstrValid  = (iq_cnt_q != '0);
    Instruction = InstrValid ? iq_data_q[iq_rd_q] : '0;
    InstrPC     = InstrValid ? iq_pc_q[iq_rd_q] : '0;
  end

  // Issue decision: a slot freed by this cycle's dequeue already counts as
  // credit, which is what sustains one fetch per cycle at DEPTH=2.
  always_comb begin
    pop_head    = InstrValid && InstrReady && !Redirect;
    credit_used = SW'(out_cnt_q) + SW'(iq_cnt_q) - SW'(pop_head);
    MemReq      = !Reset && !Redirect && (credit_used < SW'(DEPTH));
    accept      = MemReq && MemGnt;
    rsp_keep    = MemRspValid && !Redirect && (drop_cnt_q == '0);
  end

  // Next-state for PC, credit/drop counters, request PC FIFO and queue.
  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q + CW'(accept) - CW'(MemRspValid);
    drop_cnt_d = drop_cnt_q;
    rq_pc_d    = rq_pc_q;
    rq_wr_d    = rq_wr_q;
    rq_rd_d    = rq_rd_q;
    iq_data_d  = iq_data_q;
    iq_pc_d    = iq_pc_q;
    iq_wr_d    = iq_wr_q;
    iq_rd_d    = iq_rd_q;
    iq_cnt_d   = iq_cnt_q;

    if (Redirect) begin
      pc_d = {RedirectPC[63:2], 2'b00};
    end else if (accept) begin
      pc_d = pc_q + 64'd4;
    end

    // Every response still in flight at redirect time belongs to the old path.
    if (Redirect) begin
      drop_cnt_d = out_cnt_q - CW'(MemRspValid);
    end else if (MemRspValid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (accept) begin
      rq_pc_d[rq_wr_q] = pc_q;
      rq_wr_d          = ptr_inc(rq_wr_q);
    end
    if (MemRspValid) begin
      rq_rd_d = ptr_inc(rq_rd_q);
    end

    if (Redirect) begin
      iq_wr_d  = '0;
      iq_rd_d  = '0;
      iq_cnt_d = '0;
    end else begin
      if (rsp_keep) begin
        iq_data_d[iq_wr_q] = MemRspData;
        iq_pc_d[iq_wr_q]   = rq_pc_q[rq_rd_q];
        iq_wr_d            = ptr_inc(iq_wr_q);
      end
      if (pop_head) begin
        iq_rd_d = ptr_inc(iq_rd_q);
      end
      iq_cnt_d = iq_cnt_q + CW'(rsp_keep) - CW'(pop_head);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rq_wr_q    <= '0;
      rq_rd_q    <= '0;
      iq_wr_q    <= '0;
      iq_rd_q    <= '0;
      iq_cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rq_pc_q[i]   <= '0;
        iq_data_q[i] <= '0;
        iq_pc_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rq_wr_q    <= rq_wr_d;
      rq_rd_q    <= rq_rd_d;
      iq_wr_q    <= iq_wr_d;
      iq_rd_q    <= iq_rd_d;
      iq_cnt_q   <= iq_cnt_d;
      rq_pc_q    <= rq_pc_d;
      iq_data_q  <= iq_data_d;
      iq_pc_q    <= iq_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a small in-order memory model with
// adjustable response latency, a per-cycle vector table, and hand-written
// sequences for redirect-with-response and PC wrap.
module tb_instruction_fetch;

  logic        Clk;
  logic        Reset;
  logic [63:0] MemAddr;
  logic        MemReq;
  logic        MemGnt;
  logic        MemRspValid;
  logic [31:0] MemRspData;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [63:0] InstrPC;
  logic        InstrReady;
  logic        Redirect;
  logic [63:0] RedirectPC;

  instruction_fetch #(.RESET_PC(64'h038), .DEPTH(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .MemAddr(MemAddr), .MemReq(MemReq), .MemGnt(MemGnt),
    .MemRspValid(MemRspValid), .MemRspData(MemRspData),
    .InstrValid(InstrValid), .Instruction(Instruction), .InstrPC(InstrPC),
    .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h038: return 32'h8B1F03E9;
      64'h03c: return 32'hB2048D29;
      64'h05c: return 32'hB237BD29;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Memory model: accepts captured at the rising edge, responses driven at
  // the falling edge, strictly in order, rsp_lat cycles after acceptance.
  int          cyc = 0;
  int          rsp_lat = 1;
  logic [63:0] pend_addr[$];
  int          pend_due[$];

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (MemReq && MemGnt) begin
      pend_addr.push_back(MemAddr);
      pend_due.push_back(cyc + rsp_lat - 1);
    end
  end

  always @(negedge Clk) begin
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      MemRspValid = 1'b1;
      MemRspData  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      MemRspValid = 1'b0;
      MemRspData  = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ends at a falling edge with Reset just released (cycle 0 of a run).
  task automatic do_reset();
    @(negedge Clk);
    Reset      = 1'b1;
    MemGnt     = 1'b0;
    InstrReady = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    #1;
    chk("rst MemReq", 64'(MemReq), 64'd0);
    chk("rst MemAddr", MemAddr, 64'h038);
    chk("rst InstrValid", 64'(InstrValid), 64'd0);
    chk("rst Instruction", 64'(Instruction), 64'd0);
    chk("rst InstrPC", InstrPC, 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rdy;
    bit          redir;
    logic [63:0] rpc;
    int          lat;
    bit          e_req;
    logic [63:0] e_addr;
    bit          e_val;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit gnt, input bit rdy, input bit redir,
                     input logic [63:0] rpc, input int lat, input bit e_req,
                     input logic [63:0] e_addr, input bit e_val,
                     input logic [31:0] e_instr, input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.lat = lat; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
    v.e_instr = e_instr; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  initial begin
    Reset       = 1'b1;
    MemGnt      = 1'b0;
    InstrReady  = 1'b0;
    Redirect    = 1'b0;
    RedirectPC  = '0;
    MemRspValid = 1'b0;
    MemRspData  = '0;

    // Streaming from reset, 1-cycle memory, decode always ready.
    //  rst gnt rdy red rpc lat req addr    val instr          pc
    add(1, 1, 1, 0, 0, 1, 1, 64'h038, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 1, 1, 64'h03c, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 1, 1, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 1, 1, 0, 0, 1, 1, 64'h044, 1, 32'hB2048D29, 64'h03c);
    add(0, 1, 1, 0, 0, 1, 1, 64'h048, 1, 32'hC0DE0040, 64'h040);
    add(0, 1, 1, 0, 0, 1, 1, 64'h04c, 1, 32'hC0DE0044, 64'h044);
    // Decode stalled 6 cycles, then released; grant withheld 3 cycles at 0x044;
    // then 3-cycle memory and a redirect to 0x05f with two fetches in flight.
    add(1, 1, 0, 0, 0, 1, 1, 64'h038, 0, 32'h0, 64'h0);
    add(0, 1, 0, 0, 0, 1, 1, 64'h03c, 0, 32'h0, 64'h0);
    add(0, 1, 0, 0, 0, 1, 0, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 1, 0, 0, 0, 1, 0, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 1, 0, 0, 0, 1, 0, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 1, 0, 0, 0, 1, 0, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 1, 1, 0, 0, 1, 1, 64'h040, 1, 32'h8B1F03E9, 64'h038);
    add(0, 0, 1, 0, 0, 1, 1, 64'h044, 1, 32'hB2048D29, 64'h03c);
    add(0, 0, 1, 0, 0, 1, 1, 64'h044, 1, 32'hC0DE0040, 64'h040);
    add(0, 0, 1, 0, 0, 1, 1, 64'h044, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 1, 1, 64'h044, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 1, 64'h048, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 1, 64'h04c, 1, 32'hC0DE0044, 64'h044);
    add(0, 1, 1, 1, 64'h05f, 3, 0, 64'h050, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 0, 64'h05c, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 1, 64'h05c, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 1, 64'h060, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 0, 64'h064, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 0, 64'h064, 0, 32'h0, 64'h0);
    add(0, 1, 1, 0, 0, 3, 1, 64'h064, 1, 32'hB237BD29, 64'h05c);
    add(0, 1, 1, 0, 0, 3, 1, 64'h068, 1, 32'hC0DE0060, 64'h060);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      else @(negedge Clk);
      MemGnt     = vecs[i].gnt;
      InstrReady = vecs[i].rdy;
      Redirect   = vecs[i].redir;
      RedirectPC = vecs[i].rpc;
      rsp_lat    = vecs[i].lat;
      #1;
      chk($sformatf("v%0d MemReq", i), 64'(MemReq), 64'(vecs[i].e_req));
      chk($sformatf("v%0d MemAddr", i), MemAddr, vecs[i].e_addr);
      chk($sformatf("v%0d InstrValid", i), 64'(InstrValid), 64'(vecs[i].e_val));
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d Instruction", i), 64'(Instruction), 64'(vecs[i].e_instr));
        chk($sformatf("v%0d InstrPC", i), InstrPC, vecs[i].e_pc);
      end
    end

    // Redirect coinciding with a response and a ready head: response dropped,
    // queue flushed, fetch restarts at the target and its response is kept.
    do_reset();
    rsp_lat    = 1;
    MemGnt     = 1'b1;
    InstrReady = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Redirect   = 1'b1;
    RedirectPC = 64'h100;
    #1;
    chk("rdrsp head valid", 64'(InstrValid), 64'd1);
    chk("rdrsp MemReq blocked", 64'(MemReq), 64'd0);
    @(negedge Clk);
    Redirect = 1'b0;
    #1;
    chk("rdrsp flushed", 64'(InstrValid), 64'd0);
    chk("rdrsp new PC", MemAddr, 64'h100);
    chk("rdrsp MemReq", 64'(MemReq), 64'd1);
    @(negedge Clk);
    #1;
    chk("rdrsp empty", 64'(InstrValid), 64'd0);
    @(negedge Clk);
    #1;
    chk("rdrsp target valid", 64'(InstrValid), 64'd1);
    chk("rdrsp target PC", InstrPC, 64'h100);
    chk("rdrsp target instr", 64'(Instruction), 64'hC0DE0100);

    // Redirect to the last word of the address space; the PC wraps to 0.
    do_reset();
    MemGnt     = 1'b0;
    InstrReady = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("wrap MemReq in redirect", 64'(MemReq), 64'd0);
    @(negedge Clk);
    Redirect = 1'b0;
    MemGnt   = 1'b1;
    #1;
    chk("wrap MemAddr top", MemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap MemReq", 64'(MemReq), 64'd1);
    @(negedge Clk);
    #1;
    chk("wrap MemAddr zero", MemAddr, 64'h0);
    @(negedge Clk);
    #1;
    chk("wrap MemAddr four", MemAddr, 64'h4);
    chk("wrap head valid", 64'(InstrValid), 64'd1);
    chk("wrap head PC", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap head instr", 64'(Instruction), 64'hC0DEFFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end fetch unit: owns the program counter and issues word addresses to the instruction memory.
- Collects the returned 32-bit instructions and buffers them in an in-order queue.
- Hands instructions to the decode stage over a valid/ready handshake, tagged with their PC.
- Accepts branch redirects from execute, flushing the queue and any in-flight memory responses.

Parameters:
- RESET_PC, 64'h038: PC loaded on reset (program entry point).
- DEPTH, 2: instruction queue entries; also the maximum number of outstanding memory requests (credit limit).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MemAddr  output  64  fetch address to instruction memory; bits [1:0] always 0.
- MemReq  output  1  fetch request valid.
- MemGnt  input  1  memory accepts the request this cycle.
- MemRspValid  input  1  one pulse per accepted request; in order, at least 1 cycle after acceptance.
- MemRspData  input  32  instruction word, valid with MemRspValid.
- InstrValid  output  1  queue head valid to decode.
- Instruction  output  32  queue head instruction word.
- InstrPC  output  64  PC of queue head.
- InstrReady  input  1  decode consumes head when InstrValid && InstrReady.
- Redirect  input  1  single-cycle branch/redirect pulse.
- RedirectPC  input  64  new PC; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (async assert, sync release):
  - PC = RESET_PC; MemAddr = RESET_PC; MemReq = 0.
  - Queue empty; InstrValid = 0; Instruction = 0; InstrPC = 0.
  - Outstanding count = 0; drop count = 0.
- Registers: MemAddr = PC. Request PC FIFO (DEPTH entries) records the PC of each accepted request.
- Issue rule: MemReq = 1 when (outstanding + queue occupancy) < DEPTH and no Redirect this cycle. It is first asserted in the first cycle after Reset deasserts.
- Accept (MemReq && MemGnt):
  - PC <= PC + 4, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - outstanding++.
  - Push PC to the request PC FIFO.
- MemReq may stay high across cycles without MemGnt. MemAddr is stable while MemReq is high and not granted.
- Response (MemRspValid):
  - Always: outstanding--; pop the request PC FIFO.
  - If drop count > 0: drop count--; data discarded.
  - Else: push {MemRspData, popped PC} into the queue. Credit guarantees the queue is never full here.
- Dequeue: InstrValid && InstrReady pops the head. The next entry, if any, appears the following cycle. Push and pop in the same cycle are legal at any occupancy, including full.
- Latency: accept at cycle N with response at cycle N+1 gives InstrValid at N+2. Back-to-back throughput is 1 instruction/cycle with DEPTH=2 and 1-cycle memory.
- Redirect (registered, takes effect on the clock edge):
  - PC <= {RedirectPC[63:2], 2'b00}.
  - Queue flushed: InstrValid = 0 next cycle.
  - drop count <= outstanding − (MemRspValid this cycle ? 1 : 0). Any response in the redirect cycle is discarded.
  - MemReq forced 0 in the redirect cycle; no accept can occur in it.
  - A dequeue in the same cycle as Redirect is ignored; Redirect wins.
  - Requests to the new PC may issue from the next cycle while drops are still pending. Their responses are kept because drop count counts only older responses.
- Redirect back-to-back: each pulse recomputes drop count from the current outstanding count; the latest RedirectPC wins.
- Reset mid-operation: all counters, FIFOs and queue cleared immediately. Responses arriving after reset for pre-reset requests are protocol violations; the memory is reset together with this block.
- Invariants:
  - outstanding ≤ DEPTH.
  - drop count ≤ outstanding.
  - queue occupancy + outstanding ≤ DEPTH.

Test Plan:
- Reset release with 1-cycle memory (MemGnt=1) returning the program at 0x038.. (0x8B1F03E9, 0xB2048D29, ...) and InstrReady=1 → MemAddr sequence 0x038, 0x03c, 0x040...; first InstrValid 2 cycles after reset release with Instruction=0x8B1F03E9, InstrPC=0x038; then one instruction per cycle.
- InstrReady=0 for 6 cycles → exactly 2 requests accepted (0x038, 0x03c); MemReq stays low; head holds 0x8B1F03E9/0x038. Release InstrReady → stream resumes at 0x040 with no loss or duplication.
- MemGnt low for 3 cycles with MemReq high → MemAddr held at 0x044; no PC advance; accept on the 4th cycle.
- Redirect to 0x05f with 2 requests outstanding (0x048, 0x04c) and a 3-cycle response latency → both responses dropped; next InstrPC=0x05c, Instruction=0xB237BD29; InstrValid=0 in the cycle after the redirect.
- Redirect in the same cycle as MemRspValid and InstrReady → that response is discarded, the head is not popped, and PC equals the new target.
- PC set to 64'hFFFF_FFFF_FFFF_FFFC via Redirect → next MemAddr after accept is 0.
